regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file with an integrated write-pending scoreboard. It replaces the fixed 2-read/1-write register file between decode (reads, operand-readiness check) and writeback (commits), and supports dual-issue configurations. It adds three things the single-port version lacks:
- configurable read and write port counts;
- deterministic write-port priority;
- per-register busy tracking, so decode can stall on operands that are not yet written.

---
 rtl/regfile_pkg.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 74 +++++++
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and write-port priority resolve for the register file
//
// Purpose : AW derivation, zero constants, reset polarity and the write-port
//           resolve function used by every read port.
// Contents: MaxWr/MaxAw   - padded write-port count / address width used by resolve_wr
//           ZeroWord      - all-zero data word (cast to XLEN at the use site)
//           ZeroReg       - index of the hardwired-zero register
//           RstEnable     - level of rst that holds the block in reset
//           wr_sel_t      - {hit, winning port} result of resolve_wr
package regfile_pkg;

    localparam int          MaxWr     = 4;
    localparam int          MaxAw     = 16;
    localparam logic [63:0] ZeroWord  = 64'h0;
    localparam int          ZeroReg   = 0;
    localparam logic        RstEnable = 1'b0;

    typedef struct packed {
        logic       hit;
        logic [1:0] port;
    } wr_sel_t;

    function automatic int calc_aw(input int nreg);
        return (nreg < 2) ? 1 : $clog2(nreg);
    endfunction

    // Ports are scanned low to high so the highest-index enabled match wins.
    function automatic wr_sel_t resolve_wr(input logic [MaxWr-1:0]       we,
                                           input logic [MaxWr*MaxAw-1:0] waddr,
                                           input logic [MaxAw-1:0]       addr);
        wr_sel_t sel;
        sel.hit  = 1'b0;
        sel.port = 2'd0;
        for (int k = 0; k < MaxWr; k++) begin
            if (we[k] && (waddr[k*MaxAw +: MaxAw] == addr)) begin
                sel.hit  = 1'b1;
                sel.port = 2'(k);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register write-pending busy bits with alloc/clear/flush priority
//
// Purpose : one busy bit per register, set by alloc, cleared by writeback,
//           cleared wholesale by flush; looked up per read port.
// Ports   : clk, rst          - clock, asynchronous active-low reset
//           we_i/waddr_i      - write ports (clear busy of written register)
//           alloc_i/_addr_i   - mark a register pending
//           flush_i           - clear all busy bits (wins over alloc)
//           raddr_i           - packed read addresses
//           fwd_hit_i         - per read port: operand is being forwarded this cycle
//           busy_o            - per read port operand-not-ready flag
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREG    = 32,
    parameter int  NRD     = 2,
    parameter int  NWR     = 1,
    parameter bit  ZERO_R0 = 1'b1,
    localparam int AW      = calc_aw(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    we_i,
    input  logic [NWR*AW-1:0] waddr_i,
    input  logic              alloc_i,
    input  logic [AW-1:0]     alloc_addr_i,
    input  logic              flush_i,
    input  logic [NRD*AW-1:0] raddr_i,
    input  logic [NRD-1:0]    fwd_hit_i,
    output logic [NRD-1:0]    busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Order matters: write clear, then alloc set (newer producer wins), then flush.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (we_i[k]) begin
                busy_d[waddr_i[k*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_i && !(ZERO_R0 && (alloc_addr_i == AW'(ZeroReg)))) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        if (ZERO_R0) begin
            busy_d[ZeroReg] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    genvar j;
    generate
        for (j = 0; j < NRD; j++) begin : g_busy
            logic [AW-1:0] ra;
            assign ra = raddr_i[j*AW +: AW];
            assign busy_o[j] = busy_q[ra]
                               && !(ZERO_R0 && (ra == AW'(ZeroReg)))
                               && !fwd_hit_i[j];
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with write bypass and busy scoreboard
//
// Purpose : NREG x XLEN register array, NWR write ports (highest index wins),
//           NRD combinational read ports with optional same-cycle forwarding,
//           and a write-pending scoreboard for decode stalls.
// Ports   : clk, rst              - clock, asynchronous active-low reset
//           we_i/waddr_i/wdata_i  - packed write ports
//           raddr_i/rdata_o       - packed read ports (combinational)
//           busy_o                - per read port operand-not-ready
//           alloc_i/alloc_addr_i  - mark register pending
//           flush_i               - clear all busy bits
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN    = 32,
    parameter int  NREG    = 32,
    parameter int  NRD     = 2,
    parameter int  NWR     = 1,
    parameter bit  ZERO_R0 = 1'b1,
    parameter bit  BYPASS  = 1'b1,
    localparam int AW      = calc_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we_i,
    input  logic [NWR*AW-1:0]   waddr_i,
    input  logic [NWR*XLEN-1:0] wdata_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      busy_o,
    input  logic                alloc_i,
    input  logic [AW-1:0]       alloc_addr_i,
    input  logic                flush_i
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    // Write ports padded to MaxWr so the shared resolve function has fixed widths.
    logic [MaxWr-1:0]       we_pad;
    logic [MaxWr*MaxAw-1:0] waddr_pad;
    logic [XLEN-1:0]        wdata_pad [MaxWr];
    logic [NRD-1:0]         fwd_hit;

    genvar k, j;
    generate
        for (k = 0; k < MaxWr; k++) begin : g_wpad
            if (k < NWR) begin : g_used
                assign we_pad[k]                     = we_i[k];
                assign waddr_pad[k*MaxAw +: MaxAw]   = MaxAw'(waddr_i[k*AW +: AW]);
                assign wdata_pad[k]                  = wdata_i[k*XLEN +: XLEN];
            end else begin : g_unused
                assign we_pad[k]                     = 1'b0;
                assign waddr_pad[k*MaxAw +: MaxAw]   = '0;
                assign wdata_pad[k]                  = '0;
            end
        end
    endgenerate

    // Later ports overwrite earlier ones, giving highest-index priority.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NWR; p++) begin
            if (we_i[p] && !(ZERO_R0 && (waddr_i[p*AW +: AW] == AW'(ZeroReg)))) begin
                mem_d[waddr_i[p*AW +: AW]] = wdata_i[p*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= XLEN'(ZeroWord);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    generate
        for (j = 0; j < NRD; j++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd;
            wr_sel_t         sel;

            assign ra         = raddr_i[j*AW +: AW];
            assign sel        = resolve_wr(we_pad, waddr_pad, MaxAw'(ra));
            assign fwd_hit[j] = BYPASS && sel.hit;

            // Reset gating keeps write data presented during reset from leaking
            // out through the bypass path.
            always_comb begin
                rd = mem_q[ra];
                if (rst == RstEnable) begin
                    rd = XLEN'(ZeroWord);
                end else if (ZERO_R0 && (ra == AW'(ZeroReg))) begin
                    rd = XLEN'(ZeroWord);
                end else if (fwd_hit[j]) begin
                    rd = wdata_pad[sel.port];
                end
            end

            assign rdata_o[j*XLEN +: XLEN] = rd;
        end
    endgenerate

    regfile_scoreboard #(
        .NREG    (NREG),
        .NRD     (NRD),
        .NWR     (NWR),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .alloc_i      (alloc_i),
        .alloc_addr_i (alloc_addr_i),
        .flush_i      (flush_i),
        .raddr_i      (raddr_i),
        .fwd_hit_i    (fwd_hit),
        .busy_o       (busy_o)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed table-driven bench for regfile_mp (2 read, 2 write ports)
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rst;
    logic [NWR-1:0]      we_i;
    logic [NWR*AW-1:0]   waddr_i;
    logic [NWR*XLEN-1:0] wdata_i;
    logic [NRD*AW-1:0]   raddr_i;
    logic [NRD*XLEN-1:0] rdata_o;
    logic [NRD-1:0]      busy_o;
    logic                alloc_i;
    logic [AW-1:0]       alloc_addr_i;
    logic                flush_i;

    int tests_run = 0;
    int tests_failed = 0;

    regfile_mp #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .NRD     (NRD),
        .NWR     (NWR),
        .ZERO_R0 (1'b1),
        .BYPASS  (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .raddr_i      (raddr_i),
        .rdata_o      (rdata_o),
        .busy_o       (busy_o),
        .alloc_i      (alloc_i),
        .alloc_addr_i (alloc_addr_i),
        .flush_i      (flush_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        al;
        logic [4:0]  aa;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] er0;
        logic [31:0] er1;
        logic        eb0;
        logic        eb1;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic al, input logic [4:0] aa, input logic fl,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] er0, input logic [31:0] er1,
                                input logic eb0, input logic eb1);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.al = al; v.aa = aa; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
        v.er0 = er0; v.er1 = er1; v.eb0 = eb0; v.eb1 = eb1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        we_i         = '0;
        waddr_i      = '0;
        wdata_i      = '0;
        alloc_i      = 1'b0;
        alloc_addr_i = '0;
        flush_i      = 1'b0;
    endtask

    initial begin
        //               we     wa0 wd0           wa1 wd1           al aa  fl ra0 ra1 er0           er1           eb0 eb1
        vecs[0]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 5,  5,  32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(2'b01, 5,  32'hDEADBEEF, 0,  32'h0,        0, 0,  0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vecs[2]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vecs[3]  = mk(2'b11, 7,  32'h11111111, 7,  32'h22222222, 0, 0,  0, 7,  7,  32'h22222222, 32'h22222222, 0, 0);
        vecs[4]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 7,  5,  32'h22222222, 32'hDEADBEEF, 0, 0);
        vecs[5]  = mk(2'b01, 0,  32'hFFFFFFFF, 0,  32'h0,        1, 0,  0, 0,  0,  32'h0,        32'h0,        0, 0);
        vecs[6]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,        0, 0);
        vecs[7]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        1, 3,  0, 3,  3,  32'h0,        32'h0,        0, 0);
        vecs[8]  = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 3,  5,  32'h0,        32'hDEADBEEF, 1, 0);
        vecs[9]  = mk(2'b01, 3,  32'h5,        0,  32'h0,        0, 0,  0, 3,  3,  32'h5,        32'h5,        0, 0);
        vecs[10] = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 3,  3,  32'h5,        32'h5,        0, 0);
        vecs[11] = mk(2'b01, 3,  32'h6,        0,  32'h0,        1, 3,  0, 3,  3,  32'h6,        32'h6,        0, 0);
        vecs[12] = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 3,  3,  32'h6,        32'h6,        1, 1);
        vecs[13] = mk(2'b00, 0,  32'h0,        0,  32'h0,        1, 4,  0, 4,  9,  32'h0,        32'h0,        0, 0);
        vecs[14] = mk(2'b00, 0,  32'h0,        0,  32'h0,        1, 9,  0, 4,  9,  32'h0,        32'h0,        1, 0);
        vecs[15] = mk(2'b10, 0,  32'h0,        10, 32'h12345678, 1, 12, 1, 4,  9,  32'h0,        32'h0,        1, 1);
        vecs[16] = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 12, 10, 32'h0,        32'h12345678, 0, 0);
        vecs[17] = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 4,  9,  32'h0,        32'h0,        0, 0);
        vecs[18] = mk(2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0, 3,  10, 32'h6,        32'h12345678, 0, 0);

        rst = 1'b0;
        drive_idle();
        raddr_i = {5'd5, 5'd5};

        @(negedge clk);
        #2;
        check("reset_rdata0", rdata_o[31:0], 32'h0);
        check("reset_rdata1", rdata_o[63:32], 32'h0);
        check("reset_busy", {30'd0, busy_o}, 32'h0);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            we_i         = vecs[i].we;
            waddr_i      = {vecs[i].wa1, vecs[i].wa0};
            wdata_i      = {vecs[i].wd1, vecs[i].wd0};
            alloc_i      = vecs[i].al;
            alloc_addr_i = vecs[i].aa;
            flush_i      = vecs[i].fl;
            raddr_i      = {vecs[i].ra1, vecs[i].ra0};
            #2;
            check($sformatf("vec%0d_rdata0", i), rdata_o[31:0], vecs[i].er0);
            check($sformatf("vec%0d_rdata1", i), rdata_o[63:32], vecs[i].er1);
            check($sformatf("vec%0d_busy0", i), {31'd0, busy_o[0]}, {31'd0, vecs[i].eb0});
            check($sformatf("vec%0d_busy1", i), {31'd0, busy_o[1]}, {31'd0, vecs[i].eb1});
        end

        // Asynchronous reset between clock edges.
        @(negedge clk);
        drive_idle();
        we_i    = 2'b01;
        waddr_i = {5'd0, 5'd2};
        wdata_i = {32'h0, 32'hA5A5A5A5};
        alloc_i = 1'b1;
        alloc_addr_i = 5'd2;
        raddr_i = {5'd2, 5'd2};
        @(posedge clk);
        #2;
        drive_idle();
        #1;
        check("pre_reset_r2", rdata_o[31:0], 32'hA5A5A5A5);
        check("pre_reset_busy_r2", {31'd0, busy_o[0]}, 32'h1);
        rst = 1'b0;
        #1;
        check("async_reset_r2", rdata_o[31:0], 32'h0);
        check("async_reset_busy", {30'd0, busy_o}, 32'h0);
        we_i    = 2'b10;
        waddr_i = {5'd2, 5'd0};
        wdata_i = {32'h00000BAD, 32'h0};
        alloc_i = 1'b1;
        alloc_addr_i = 5'd2;
        #1;
        check("reset_no_bypass", rdata_o[63:32], 32'h0);
        @(posedge clk);
        #2;
        check("reset_write_lost", rdata_o[63:32], 32'h0);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #1;
        check("post_reset_r2", rdata_o[31:0], 32'h0);
        check("post_reset_busy", {30'd0, busy_o}, 32'h0);
        @(negedge clk);
        we_i    = 2'b01;
        waddr_i = {5'd0, 5'd2};
        wdata_i = {32'h0, 32'h00000077};
        @(posedge clk);
        #2;
        drive_idle();
        #1;
        check("first_write_after_reset", rdata_o[31:0], 32'h00000077);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
